// File: rtl/booth_mac_pkg.sv
// Shared types and helpers for the Booth MAC sequencer.
// Holds the FSM state encoding, default widths, sign extension and the
// signed accumulator limit functions.
package booth_mac_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 24;
  localparam int unsigned LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Sign-extend the low w bits of v to 64 bits; caller truncates to its width.
  function automatic logic signed [63:0] sign_ext(input logic [63:0] v, input int unsigned w);
    logic signed [63:0] t;
    t = signed'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Largest positive value of a w-bit signed number.
  function automatic logic signed [63:0] acc_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value of a w-bit signed number.
  function automatic logic signed [63:0] acc_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_acc_unit.sv
// Combinational accumulate step for the Booth MAC sequencer.
// Ports:
//   acc        current accumulator value
//   p          sign-extended product to add
//   first      1 when p opens a new frame (result is p, no overflow)
//   acc_next_c next accumulator value
//   ovf_c      signed overflow on this add
// Build option MAC_SAT_EN: clamp to the signed limits on overflow instead of
// wrapping modulo 2^ACC_W.
module mac_acc_unit
  import booth_mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] p,
  input  logic                    first,
  output logic signed [ACC_W-1:0] acc_next_c,
  output logic                    ovf_c
);

  logic signed [ACC_W-1:0] sum;

  // Overflow: both addends share a sign and the sum's sign differs from it.
  always_comb begin
    sum        = acc + p;
    acc_next_c = sum;
    ovf_c      = 1'b0;
    if (first) begin
      acc_next_c = p;
    end else if ((acc[ACC_W-1] == p[ACC_W-1]) && (sum[ACC_W-1] != p[ACC_W-1])) begin
      ovf_c = 1'b1;
`ifdef MAC_SAT_EN
      acc_next_c = p[ACC_W-1] ? ACC_W'(acc_min(ACC_W)) : ACC_W'(acc_max(ACC_W));
`endif
    end
  end

endmodule

// File: rtl/booth_mac_sequencer.sv
// Feeds signed operand pairs to an external Booth multiplier and accumulates
// the products into per-frame sums.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   op_valid/op_ready/op_a/op_b/op_last  operand stream; op_last closes a frame
//   mul_start_sig/mul_a/mul_b        request to the multiplier
//   mul_done_sig/mul_product         one-cycle completion with signed product
//   res_valid/res_ready              frame result handshake
//   res_sum/res_count/res_ovf/res_trunc  frame sum, terms, sticky overflow,
//                                    force-closed at maximum length
// Build option MAC_SAT_EN: saturating accumulation (see mac_acc_unit).
module booth_mac_sequencer
  import booth_mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  input  logic                     op_last,
  output logic                     mul_start_sig,
  output logic signed [DATA_W-1:0] mul_a,
  output logic signed [DATA_W-1:0] mul_b,
  input  logic                     mul_done_sig,
  input  logic signed [2*DATA_W-1:0] mul_product,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_sum,
  output logic [LEN_W-1:0]         res_count,
  output logic                     res_ovf,
  output logic                     res_trunc
);

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_e                   state_q, state_nxt;
  logic                     last_q, last_nxt;
  logic                     first_q, first_nxt;
  logic signed [ACC_W-1:0]  acc_q, acc_nxt;
  logic [LEN_W-1:0]         cnt_q, cnt_nxt;
  logic                     ovf_q, ovf_nxt;

  logic                     ready_nxt, start_nxt;
  logic signed [DATA_W-1:0] a_nxt, b_nxt;
  logic                     rv_nxt, ro_nxt, rt_nxt;
  logic signed [ACC_W-1:0]  rs_nxt;
  logic [LEN_W-1:0]         rc_nxt;

  logic signed [ACC_W-1:0]  p_c;
  logic signed [ACC_W-1:0]  acc_step_c;
  logic                     ovf_step_c;

  assign p_c = ACC_W'(sign_ext(64'(mul_product), 2 * DATA_W));

  mac_acc_unit #(
    .ACC_W (ACC_W)
  ) u_acc (
    .acc        (acc_q),
    .p          (p_c),
    .first      (first_q),
    .acc_next_c (acc_step_c),
    .ovf_c      (ovf_step_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b0;
      first_q       <= 1'b1;
      acc_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      op_ready      <= 1'b0;
      mul_start_sig <= 1'b0;
      mul_a         <= '0;
      mul_b         <= '0;
      res_valid     <= 1'b0;
      res_sum       <= '0;
      res_count     <= '0;
      res_ovf       <= 1'b0;
      res_trunc     <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      last_q        <= last_nxt;
      first_q       <= first_nxt;
      acc_q         <= acc_nxt;
      cnt_q         <= cnt_nxt;
      ovf_q         <= ovf_nxt;
      op_ready      <= ready_nxt;
      mul_start_sig <= start_nxt;
      mul_a         <= a_nxt;
      mul_b         <= b_nxt;
      res_valid     <= rv_nxt;
      res_sum       <= rs_nxt;
      res_count     <= rc_nxt;
      res_ovf       <= ro_nxt;
      res_trunc     <= rt_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state_q;
    last_nxt  = last_q;
    first_nxt = first_q;
    acc_nxt   = acc_q;
    cnt_nxt   = cnt_q;
    ovf_nxt   = ovf_q;
    start_nxt = mul_start_sig;
    a_nxt     = mul_a;
    b_nxt     = mul_b;
    rv_nxt    = res_valid;
    rs_nxt    = res_sum;
    rc_nxt    = res_count;
    ro_nxt    = res_ovf;
    rt_nxt    = res_trunc;

    case (state_q)
      ST_IDLE: begin
        if (op_valid && op_ready) begin
          a_nxt     = op_a;
          b_nxt     = op_b;
          last_nxt  = op_last;
          start_nxt = 1'b1;
          state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done_sig) begin
          start_nxt = 1'b0;
          acc_nxt   = acc_step_c;
          cnt_nxt   = first_q ? LEN_W'(1) : cnt_q + LEN_W'(1);
          ovf_nxt   = first_q ? ovf_step_c : (ovf_q | ovf_step_c);
          first_nxt = 1'b0;
          if (last_q || (cnt_nxt == CNT_MAX)) begin
            state_nxt = ST_OUT;
            rv_nxt    = 1'b1;
            rs_nxt    = acc_step_c;
            rc_nxt    = cnt_nxt;
            ro_nxt    = ovf_nxt;
            rt_nxt    = !last_q;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          rv_nxt    = 1'b0;
          first_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Ready only in IDLE; rising one cycle after done keeps starts spaced apart.
    ready_nxt = (state_nxt == ST_IDLE);
  end

endmodule

// File: doc/booth_mac_sequencer.md
Name: booth_mac_sequencer

Overview:
- Sits directly upstream and downstream of the 8-bit Booth multiplier.
- Accepts a stream of signed operand pairs through a valid/ready handshake and issues each pair to the multiplier using the start_sig/done_sig handshake.
- Sign-extends each returned product and accumulates it into a frame sum; op_last closes a frame.
- Presents the frame sum, term count and status flags on a valid/ready result port.

Parameters:
- DATA_W, 8: operand width; the multiplier product is 2*DATA_W bits, signed.
- ACC_W, 24: accumulator and result width, signed; must be >= 2*DATA_W.
- LEN_W, 4: width of the term counter; a frame holds at most 2^LEN_W-1 terms.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  sequencer can accept a pair.
- op_a  in  DATA_W  signed multiplicand.
- op_b  in  DATA_W  signed multiplier.
- op_last  in  1  this pair is the final term of the frame.
- mul_start_sig  out  1  start request to the multiplier.
- mul_a  out  DATA_W  multiplier A operand.
- mul_b  out  DATA_W  multiplier B operand.
- mul_done_sig  in  1  multiplier completion, one-cycle pulse.
- mul_product  in  2*DATA_W  signed product; valid while mul_done_sig=1.
- res_valid  out  1  frame result available.
- res_ready  in  1  consumer takes the result.
- res_sum  out  ACC_W  signed frame sum.
- res_count  out  LEN_W  number of terms in the frame.
- res_ovf  out  1  sticky overflow seen in this frame.
- res_trunc  out  1  frame was force-closed at maximum length.

Behaviour:
- All outputs are registered. Reset values are all 0: op_ready=0, mul_start_sig=0, mul_a=0, mul_b=0, res_valid=0, res_sum=0, res_count=0, res_ovf=0, res_trunc=0. The FSM resets to IDLE and the internal first flag resets to 1.
- FSM states: IDLE, MUL, OUT.
- IDLE:
  - op_ready=1.
  - On op_valid&&op_ready: latch op_a/op_b into mul_a/mul_b, latch op_last, set mul_start_sig=1, op_ready=0, go to MUL.
- MUL:
  - mul_start_sig and mul_a/mul_b are held stable until mul_done_sig is sampled 1. There is no timeout.
  - On done, in the same edge:
    - mul_start_sig<=0.
    - Compute p = sign-extend(mul_product) to ACC_W.
    - acc <= first ? p : acc+p.
    - count <= first ? 1 : count+1.
    - ovf updated; first<=0.
  - If the latched op_last=1, or the new count equals 2^LEN_W-1: go to OUT with res_valid=1. res_trunc=1 only when the count limit closed the frame without op_last.
  - Otherwise go back to IDLE.
- Start spacing: op_ready rises only in the cycle after done is sampled, so mul_start_sig is low for at least one cycle between operations. The multiplier requires this.
- Issue rate: one term per (multiplier latency + 1) cycles.
- OUT:
  - res_* are held stable while res_valid=1 && !res_ready; op_ready=0.
  - When res_ready is sampled 1: res_valid<=0, first<=1, go to IDLE.
  - res_ready already high in the first cycle of res_valid: the transfer completes on that edge.
- Overflow: set when the sign of acc+p differs from the signs of both equal-signed addends. It is sticky until the frame is consumed.
- Wrap: default arithmetic is modulo 2^ACC_W.
- mul_done_sig in IDLE or OUT is ignored.
- Asynchronous reset mid-frame abandons the frame. The result is never emitted and mul_start_sig drops immediately.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: on overflow, acc clamps to +(2^(ACC_W-1))-1 or -2^(ACC_W-1), according to the addend sign. Later terms continue from the clamped value. res_ovf is still set.
- Undefined: wrapping arithmetic. res_ovf is set identically in both cases.

Decomposition:
- Package booth_mac_pkg holds:
  - the FSM state encoding (IDLE/MUL/OUT);
  - default DATA_W/ACC_W/LEN_W constants;
  - functions for sign extension and for the ACC_W signed max/min limits.
- Sub-module mac_acc_unit, combinational, holds the adder, overflow detect and MAC_SAT_EN clamp. Inputs: acc, p, first. Outputs: next acc, ovf.
- The FSM, the handshakes and the registers stay in booth_mac_sequencer.

Test Plan:
- Basic frame: send (2,4), (-4,4), (127,-127), (-127,-127) with last on the 4th, multiplier in loop, res_ready=1. Expect one result: res_sum=-8 (0xFFFFF8), res_count=4, ovf=0, trunc=0. mul_start_sig is low at least 1 cycle between the 4 starts.
- Backpressure: same frame with res_ready=0 for 5 cycles after res_valid. Expect res_* stable, op_ready=0 throughout, and a new frame accepted only after the res_ready edge.
- Overflow: ACC_W=16, three terms (-127,-127), last on the 3rd. Without MAC_SAT_EN: res_sum=-17149, res_ovf=1. With it: res_sum=32767, res_ovf=1.
- Truncation: LEN_W=2, stream 4 pairs of (1,1) with last only on the 4th. Expect frame 1 with sum=3, count=3, trunc=1; frame 2 with sum=1, count=1, trunc=0.
- Reset mid-MUL: drop rst_n while mul_start_sig=1. Expect all outputs 0 asynchronously. After release, op_ready=1 in the first clocked cycle and the next frame starts clean (2*4 alone gives sum 8).
- Idle stray done: pulse mul_done_sig with mul_product=0x1234 while in IDLE. Expect no state change and no result.
